// File: rtl/ts_pkg.sv
// Shared TS constants, sync states and routing types for the demux datapath.
package ts_pkg;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;
    localparam int         TS_PID_W     = 13;
    localparam int         TS_POS_W     = 8;
    localparam int         NUM_CH       = 4;
    localparam int         CH_W         = $clog2(NUM_CH);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} sync_state_t;

    typedef struct packed {
        logic                en;
        logic [TS_PID_W-1:0] pid;
    } pid_entry_t;

    typedef struct packed {
        logic            vld;
        logic [CH_W-1:0] ch;
    } route_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction
endpackage

// File: rtl/ts_sync_tracker.sv
// Packet sync acquisition: byte position counter with flywheel, HUNT/VERIFY/LOCKED
// state and saturating count of bad sync positions.
module ts_sync_tracker
    import ts_pkg::*;
#(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 3,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          DATA_IN,
    input  logic                D_VALID_IN,
    input  logic                P_SYNC_IN,
    output logic [TS_POS_W-1:0] POS,
    output logic                LOCKED,
    output logic [CNT_W-1:0]    SYNC_ERR_CNT
);
    sync_state_t         state_q, state_d;
    logic [3:0]          good_q, good_d, bad_q, bad_d;
    logic [TS_POS_W-1:0] pos_d;
    logic                is_sync, err_inc;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_inc = 1'b0;
        is_sync = P_SYNC_IN && (DATA_IN == TS_SYNC_BYTE);
        pos_d   = (POS == TS_POS_W'(TS_PKT_LEN - 1)) ? '0 : POS + 1'b1;
        if (D_VALID_IN) begin
            case (state_q)
                ST_HUNT: if (is_sync) begin
                    // current byte becomes position 0 of the candidate packet
                    state_d = ST_VERIFY;
                    good_d  = '0;
                    pos_d   = TS_POS_W'(1);
                end
                ST_VERIFY: if (POS == '0) begin
                    if (is_sync) begin
                        good_d = good_q + 1'b1;
                        if (good_q == 4'(LOCK_N - 1)) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        err_inc = 1'b1;
                    end
                end
                ST_LOCKED: if (POS == '0) begin
                    // bad positions keep the flywheel counter running; no re-align
                    if (is_sync) begin
                        bad_d = '0;
                    end else begin
                        err_inc = 1'b1;
                        bad_d   = bad_q + 1'b1;
                        if (bad_q == 4'(UNLOCK_N - 1)) begin
                            state_d = ST_HUNT;
                            bad_d   = '0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_HUNT;
            good_q       <= '0;
            bad_q        <= '0;
            POS          <= '0;
            LOCKED       <= 1'b0;
            SYNC_ERR_CNT <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            LOCKED  <= (state_d == ST_LOCKED);
            if (D_VALID_IN)
                POS <= pos_d;
            if (err_inc && !(&SYNC_ERR_CNT))
                SYNC_ERR_CNT <= SYNC_ERR_CNT + 1'b1;
        end
    end
endmodule

// File: rtl/ts_demuxer.sv
// Routes each 188-byte TS packet to one of NUM_CH channels by PID table lookup;
// errored, unmatched or unlocked packets leave with no channel valid.
module ts_demuxer
    import ts_pkg::*;
#(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 3,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          DATA_IN,
    input  logic                D_VALID_IN,
    input  logic                P_SYNC_IN,
    input  logic                CFG_WE,
    input  logic [CH_W-1:0]     CFG_ADDR,
    input  logic [TS_PID_W-1:0] CFG_PID,
    input  logic                CFG_EN,
    output logic [7:0]          DATA_OUT,
    output logic [NUM_CH-1:0]   D_VALID_BUS,
    output logic [NUM_CH-1:0]   P_SYNC_BUS,
    output logic                LOCKED,
    output logic [CNT_W-1:0]    SYNC_ERR_CNT,
    output logic [CNT_W-1:0]    DROP_CNT
);
    pid_entry_t          pid_tab [NUM_CH];
    logic [TS_POS_W-1:0] pos;
    logic [1:0][7:0]     dly;
    logic [1:0]          vld_pipe;
    logic                hdr_tei;
    logic [4:0]          hdr_pid_hi;
    logic [TS_PID_W-1:0] pid;
    logic                hit, hdr_beat, emit, drop;
    logic [CH_W-1:0]     hit_ch;
    route_t              route_q, route_new, route_cur;

    ts_sync_tracker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(CNT_W)) u_sync (
        .CLK          (CLK),
        .RST          (RST),
        .DATA_IN      (DATA_IN),
        .D_VALID_IN   (D_VALID_IN),
        .P_SYNC_IN    (P_SYNC_IN),
        .POS          (pos),
        .LOCKED       (LOCKED),
        .SYNC_ERR_CNT (SYNC_ERR_CNT)
    );

    always_comb begin
        pid      = {hdr_pid_hi, DATA_IN};
        hdr_beat = D_VALID_IN && (pos == TS_POS_W'(2));
        emit     = D_VALID_IN && vld_pipe[1];
        hit      = 1'b0;
        hit_ch   = '0;
        // descending scan so the lowest matching channel wins
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (pid_tab[n].en && pid_tab[n].pid == pid) begin
                hit    = 1'b1;
                hit_ch = CH_W'(n);
            end
        end
        route_new.vld = LOCKED && !hdr_tei && hit;
        route_new.ch  = hit_ch;
        drop          = hdr_beat && LOCKED && !route_new.vld;
        // byte 0 exits on the same beat byte 2 enters, so it needs the fresh decision
        route_cur     = hdr_beat ? route_new : route_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < NUM_CH; n++)
                pid_tab[n] <= '0;
            dly         <= '0;
            vld_pipe    <= '0;
            hdr_tei     <= 1'b0;
            hdr_pid_hi  <= '0;
            route_q     <= '0;
            DATA_OUT    <= '0;
            D_VALID_BUS <= '0;
            P_SYNC_BUS  <= '0;
            DROP_CNT    <= '0;
        end else begin
            if (CFG_WE)
                pid_tab[CFG_ADDR] <= '{en: CFG_EN, pid: CFG_PID};
            D_VALID_BUS <= '0;
            P_SYNC_BUS  <= '0;
            if (D_VALID_IN) begin
                dly      <= {dly[0], DATA_IN};
                vld_pipe <= {vld_pipe[0], 1'b1};
                if (pos == TS_POS_W'(1)) begin
                    hdr_tei    <= DATA_IN[7];
                    hdr_pid_hi <= DATA_IN[4:0];
                end
                if (hdr_beat)
                    route_q <= route_new;
                if (emit) begin
                    DATA_OUT <= dly[1];
                    if (route_cur.vld) begin
                        D_VALID_BUS <= ch_onehot(route_cur.ch);
                        if (hdr_beat)
                            P_SYNC_BUS <= ch_onehot(route_cur.ch);
                    end
                end
            end
            if (drop && !(&DROP_CNT))
                DROP_CNT <= DROP_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_ts_demuxer.sv
// Self-checking bench: random payloads, packet-level reference model and output scoreboard.
module tb_ts_demuxer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  DATA_IN = '0;
    logic        D_VALID_IN = 1'b0;
    logic        P_SYNC_IN = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [1:0]  CFG_ADDR = '0;
    logic [12:0] CFG_PID = '0;
    logic        CFG_EN = 1'b0;
    logic [7:0]  DATA_OUT;
    logic [3:0]  D_VALID_BUS, P_SYNC_BUS;
    logic        LOCKED;
    logic [15:0] SYNC_ERR_CNT, DROP_CNT;

    always #5 CLK = ~CLK;

    ts_demuxer #(.LOCK_N(3), .UNLOCK_N(3), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN),
        .P_SYNC_IN(P_SYNC_IN), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_PID(CFG_PID), .CFG_EN(CFG_EN), .DATA_OUT(DATA_OUT),
        .D_VALID_BUS(D_VALID_BUS), .P_SYNC_BUS(P_SYNC_BUS), .LOCKED(LOCKED),
        .SYNC_ERR_CNT(SYNC_ERR_CNT), .DROP_CNT(DROP_CNT)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: sync state tracked per packet, expected routed bytes in a queue
    typedef struct packed { logic [7:0] d; logic [3:0] m; logic [3:0] ps; } ob_t;
    ob_t         exp_q[$];
    ob_t         mon_e;
    int          m_st, m_good, m_bad, m_serr, m_drop;
    logic [12:0] m_pid [4];
    logic        m_en  [4];
    logic [7:0]  pkt   [188];

    task automatic model_reset();
        m_st = 0; m_good = 0; m_bad = 0; m_serr = 0; m_drop = 0;
        for (int n = 0; n < 4; n++) begin m_pid[n] = '0; m_en[n] = 1'b0; end
        exp_q.delete();
    endtask

    task automatic model_pkt();
        logic        ok, tei;
        logic [12:0] p;
        int          ch;
        ok = (pkt[0] == 8'h47);
        case (m_st)
            0: if (ok) begin m_st = 1; m_good = 0; end
            1: if (ok) begin m_good++; if (m_good == 3) begin m_st = 2; m_bad = 0; end end
               else begin m_st = 0; m_serr++; end
            default: if (ok) m_bad = 0;
               else begin m_serr++; m_bad++; if (m_bad == 3) begin m_st = 0; m_bad = 0; end end
        endcase
        tei = pkt[1][7];
        p   = {pkt[1][4:0], pkt[2]};
        ch  = -1;
        for (int n = 0; n < 4; n++)
            if (ch < 0 && m_en[n] && m_pid[n] == p) ch = n;
        if (m_st == 2 && !tei && ch >= 0) begin
            for (int i = 0; i < 188; i++)
                exp_q.push_back('{d: pkt[i], m: 4'(1 << ch), ps: (i == 0) ? 4'(1 << ch) : 4'h0});
        end else if (m_st == 2) begin
            m_drop++;
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (D_VALID_BUS != 4'h0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {16'h0, DATA_OUT, D_VALID_BUS, P_SYNC_BUS}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_byte", {16'h0, DATA_OUT, D_VALID_BUS, P_SYNC_BUS},
                        {16'h0, mon_e.d, mon_e.m, mon_e.ps});
                end
            end else if (P_SYNC_BUS != 4'h0) begin
                chk("psync_idle", {28'h0, P_SYNC_BUS}, 32'h0);
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic s);
        D_VALID_IN = 1'b1; DATA_IN = d; P_SYNC_IN = s;
        @(posedge CLK); #1;
        D_VALID_IN = 1'b0; P_SYNC_IN = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [12:0] p, input logic e);
        CFG_WE = 1'b1; CFG_ADDR = a; CFG_PID = p; CFG_EN = e;
        @(posedge CLK); #1;
        CFG_WE = 1'b0;
        m_pid[a] = p; m_en[a] = e;
    endtask

    task automatic build_pkt(input logic [12:0] pid, input logic tei, input logic bad);
        pkt[0] = bad ? 8'h46 : 8'h47;
        pkt[1] = {tei, 2'($urandom_range(0, 3)), pid[12:8]};
        pkt[2] = pid[7:0];
        for (int i = 3; i < 188; i++) pkt[i] = 8'($urandom);
    endtask

    // cfg_at >= 3 writes ch0 PID mid-packet; nbytes < 188 leaves the packet partial
    task automatic send_pkt(input logic [12:0] pid, input logic tei, input logic bad,
                            input int gap_pct, input int cfg_at, input logic [12:0] cfg_pid,
                            input int nbytes);
        build_pkt(pid, tei, bad);
        model_pkt();
        for (int i = 0; i < nbytes; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(posedge CLK); #1;
            end
            if (i == cfg_at) begin
                CFG_WE = 1'b1; CFG_ADDR = 2'd0; CFG_PID = cfg_pid; CFG_EN = 1'b1;
            end
            beat(pkt[i], i == 0);
            CFG_WE = 1'b0;
        end
        if (cfg_at >= 0) m_pid[0] = cfg_pid;
        chk("locked", {31'h0, LOCKED}, (m_st == 2) ? 32'd1 : 32'd0);
        chk("sync_err_cnt", {16'h0, SYNC_ERR_CNT}, 32'(m_serr));
        chk("drop_cnt", {16'h0, DROP_CNT}, 32'(m_drop));
    endtask

    task automatic pkt_n(input logic [12:0] pid, input logic tei, input logic bad, input int gap);
        send_pkt(pid, tei, bad, gap, -1, 13'h0, 188);
    endtask

    task automatic chk_rst_outputs();
        chk("rst_data", {24'h0, DATA_OUT}, 32'h0);
        chk("rst_dvbus", {28'h0, D_VALID_BUS}, 32'h0);
        chk("rst_psbus", {28'h0, P_SYNC_BUS}, 32'h0);
        chk("rst_locked", {31'h0, LOCKED}, 32'h0);
        chk("rst_serr", {16'h0, SYNC_ERR_CNT}, 32'h0);
        chk("rst_drop", {16'h0, DROP_CNT}, 32'h0);
    endtask

    task automatic load_table();
        cfg_wr(2'd0, 13'h100, 1'b1);
        cfg_wr(2'd1, 13'h200, 1'b1);
        cfg_wr(2'd2, 13'h300, 1'b1);
        cfg_wr(2'd3, 13'h400, 1'b1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [12:0] pids [5];
        pids = '{13'h100, 13'h200, 13'h300, 13'h400, 13'h555};
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk_rst_outputs();
        RST = 1'b0;
        load_table();

        // acquisition: three packets dropped, then ch1
        repeat (6) pkt_n(13'h200, 1'b0, 1'b0, 0);

        // interleaved PIDs incl. an unmatched one
        repeat (2) begin
            pkt_n(13'h100, 1'b0, 1'b0, 0);
            pkt_n(13'h400, 1'b0, 1'b0, 0);
            pkt_n(13'h555, 1'b0, 1'b0, 0);
        end

        // single corrupt sync (flywheel), then three in a row -> loss and reacquire
        pkt_n(13'h100, 1'b0, 1'b1, 0);
        pkt_n(13'h100, 1'b0, 1'b0, 0);
        repeat (3) pkt_n(13'h100, 1'b0, 1'b1, 0);
        repeat (5) pkt_n(13'h100, 1'b0, 1'b0, 0);

        // transport error indicator
        pkt_n(13'h100, 1'b1, 1'b0, 0);
        pkt_n(13'h100, 1'b0, 1'b0, 0);

        // gappy input, mid-packet table update
        repeat (6) pkt_n(pids[$urandom_range(0, 4)], 1'b0, 1'b0, 50);
        send_pkt(13'h100, 1'b0, 1'b0, 50, 60, 13'h123, 188);
        pkt_n(13'h123, 1'b0, 1'b0, 50);
        pkt_n(13'h100, 1'b0, 1'b0, 50);
        pkt_n(13'h555, 1'b0, 1'b0, 50);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a routed packet
        send_pkt(13'h200, 1'b0, 1'b0, 0, -1, 13'h0, 50);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk_rst_outputs();
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 50; i < 188; i++) beat(pkt[i], 1'b0);
        load_table();
        repeat (5) pkt_n(13'h300, 1'b0, 1'b0, 0);
        pkt_n(13'h555, 1'b0, 1'b0, 0);
        chk("queue_drained_post_rst", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
